// File: rtl/divisor_secuencial_param.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned per operation.
// Latency W+1 cycles from Start to Done; Start is ignored while Busy.
module divisor_secuencial_param #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic [W-1:0] num_i,
  input  logic [W-1:0] den_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] coc_o,
  output logic [W-1:0] res_o,
  output logic         div_zero_o,
  output logic         ovf_o
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  dmag_q, dmag_d;
  logic [W-1:0]  num_q, num_d;
  logic          nneg_q, nneg_d;
  logic          dneg_q, dneg_d;
  logic [W-1:0]  coc_q, coc_d;
  logic [W-1:0]  res_q, res_d;
  logic          dz_q, dz_d;
  logic          ov_q, ov_d;
  logic          done_q, done_d;

  // The partial remainder is W+1 bits only transiently: after the
  // conditional subtract it is always below |Den| and fits in W bits.
  logic [W:0]    r_shift;
  logic [W-1:0]  r_sub;
  logic          ovf_cond;

  assign r_shift  = {r_q, a_q[W-1]};
  assign r_sub    = r_shift[W-1:0] - dmag_q;
  assign ovf_cond = nneg_q && dneg_q && (num_q == MOST_NEG) && (dmag_q == W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    a_d     = a_q;
    dmag_d  = dmag_q;
    num_d   = num_q;
    nneg_d  = nneg_q;
    dneg_d  = dneg_q;
    coc_d   = coc_q;
    res_d   = res_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CALC;
          nneg_d  = signed_i && num_i[W-1];
          dneg_d  = signed_i && den_i[W-1];
          a_d     = (signed_i && num_i[W-1]) ? -num_i : num_i;
          dmag_d  = (signed_i && den_i[W-1]) ? -den_i : den_i;
          num_d   = num_i;
          r_d     = '0;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        // Numerator register doubles as the quotient shift register.
        if (r_shift >= {1'b0, dmag_q}) begin
          r_d = r_sub;
          a_d = {a_q[W-2:0], 1'b1};
        end else begin
          r_d = r_shift[W-1:0];
          a_d = {a_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dmag_q == '0) begin
          coc_d = '1;
          res_d = num_q;
          dz_d  = 1'b1;
          ov_d  = 1'b0;
        end else begin
          coc_d = (nneg_q ^ dneg_q) ? -a_q : a_q;
          res_d = nneg_q ? -r_q : r_q;
          dz_d  = 1'b0;
          ov_d  = ovf_cond;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      a_q     <= '0;
      dmag_q  <= '0;
      num_q   <= '0;
      nneg_q  <= 1'b0;
      dneg_q  <= 1'b0;
      coc_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      a_q     <= a_d;
      dmag_q  <= dmag_d;
      num_q   <= num_d;
      nneg_q  <= nneg_d;
      dneg_q  <= dneg_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign coc_o      = coc_q;
  assign res_o      = res_q;
  assign div_zero_o = dz_q;
  assign ovf_o      = ov_q;

endmodule
